lockin_avmm_cmd_master: RTL and testbench



---
 rtl/lockin_avmm_cmd_master_pkg.sv | 19 +
 rtl/lockin_avmm_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_lockin_avmm_cmd_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lockin_avmm_cmd_master_pkg.sv
// Shared types for the lock-in Avalon-MM command master: FSM states,
// data width and the response record.
package lockin_avmm_pkg;

    localparam int unsigned AVMM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RDWAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [AVMM_DATA_W-1:0] readdata;
        logic                   error;
    } rsp_t;

endpackage

// File: rtl/lockin_avmm_cmd_master.sv
// Single-outstanding Avalon-MM initiator turning fabric commands into
// register transfers. Optional waitrequest timeout: LOCKIN_AVMM_CMD_TIMEOUT_EN.
module lockin_avmm_cmd_master
    import lockin_avmm_pkg::*;
#(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned TIMEOUT_CYC  = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_address,
    input  logic [AVMM_DATA_W-1:0] cmd_writedata,
    output logic                   rsp_valid,
    output logic [AVMM_DATA_W-1:0] rsp_readdata,
    output logic                   rsp_error,
    output logic [ADDR_W-1:0]      avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write_n,
    output logic                   avm_read,
    output logic [AVMM_DATA_W-1:0] avm_writedata,
    input  logic [AVMM_DATA_W-1:0] avm_readdata,
    input  logic                   avm_waitrequest
);

    localparam logic [1:0]  LAT     = READ_LATENCY[1:0];
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_write;
    logic [ADDR_W-1:0]      r_address;
    logic [AVMM_DATA_W-1:0] r_writedata;
    logic                   r_cs;
    logic                   r_read;
    logic                   r_write_n;
    logic [1:0]             r_lat_cnt;
    logic                   r_rsp_valid;
    rsp_t                   r_rsp;

    logic                   w_load;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_to_hit;
    logic                   w_xfer_nxt;
    logic                   w_wr_nxt;

`ifdef LOCKIN_AVMM_CMD_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Held at zero outside XFER, so every new transfer starts a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state != XFER) begin
            r_to_cnt <= '0;
        end else if (avm_waitrequest) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_to_hit = avm_waitrequest && (r_to_cnt == TO_LAST);
`else
    logic w_unused_to;

    assign w_to_hit    = 1'b0;
    assign w_unused_to = ^TO_LAST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (!avm_waitrequest) begin
                    if (r_write) begin
                        w_state_nxt = RESP;
                    end else if (LAT == 2'd0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = RDWAIT;
                    end
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RDWAIT: begin
                if (r_lat_cnt == LAT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with XFER.
    assign w_xfer_nxt = (w_state_nxt == XFER);
    assign w_wr_nxt   = w_load ? cmd_write : r_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
            r_cs        <= 1'b0;
            r_read      <= 1'b0;
            r_write_n   <= 1'b1;
            r_lat_cnt   <= 2'd1;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            if (w_load) begin
                r_write     <= cmd_write;
                r_address   <= cmd_address;
                r_writedata <= cmd_writedata;
            end
            r_cs      <= w_xfer_nxt;
            r_read    <= w_xfer_nxt & ~w_wr_nxt;
            r_write_n <= ~(w_xfer_nxt & w_wr_nxt);

            if (r_state == RDWAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end else begin
                r_lat_cnt <= 2'd1;
            end

            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_state_nxt == RESP) begin
                r_rsp.readdata <= w_capture ? avm_readdata : '0;
                r_rsp.error    <= w_timeout;
            end else begin
                r_rsp <= '0;
            end
        end
    end

    assign cmd_ready      = (r_state == IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_readdata   = r_rsp.readdata;
    assign rsp_error      = r_rsp.error;
    assign avm_address    = r_address;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_write_n;
    assign avm_read       = r_read;
    assign avm_writedata  = r_writedata;

endmodule

// File: tb/tb_lockin_avmm_cmd_master.sv
// Self-checking bench for lockin_avmm_cmd_master: behavioural slave plus a
// register-bank reference model; timing derived from the command rules.
module tb_lockin_avmm_cmd_master;

    localparam int L  = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        rsp_error;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_vec = 0;
    int n_err = 0;

    // slave behaviour
    logic [31:0] slave_mem [4] = '{default: 32'h0};
    int          wait_target = 0;
    bit          stuck = 1'b0;
    int          wait_seen = 0;
    logic [1:0]  hold_addr = 2'd0;
    int          since = 0;

    // reference model of the register bank
    logic [31:0] ref_mem [4];

    lockin_avmm_cmd_master #(
        .ADDR_W       (2),
        .READ_LATENCY (L),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_writedata   (cmd_writedata),
        .rsp_valid       (rsp_valid),
        .rsp_readdata    (rsp_readdata),
        .rsp_error       (rsp_error),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest = avm_chipselect && (stuck || (wait_seen < wait_target));

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && !avm_waitrequest)
            slave_mem[avm_address] <= avm_writedata;
        if (!avm_chipselect) wait_seen <= 0;
        else if (avm_waitrequest) wait_seen <= wait_seen + 1;
        if (avm_chipselect && avm_read && !avm_waitrequest) begin
            hold_addr <= avm_address;
            since     <= 1;
        end else if (since != 0 && since < 7) begin
            since <= since + 1;
        end
    end

    // Read data is only valid in the one cycle the latency rule names.
    always_comb begin
        if (L == 0)
            avm_readdata = (avm_chipselect && avm_read && !avm_waitrequest) ?
                           slave_mem[avm_address] : 32'hBAD0_0BAD;
        else
            avm_readdata = (since == L) ? slave_mem[hold_addr] : (32'hBAD0_0000 + since);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command at a negedge while idle; checks strobes, latency and response.
    task automatic do_cmd(input bit wr, input logic [1:0] a, input logic [31:0] d,
                          input int waits, input bit stuck_en);
        int          off;
        int          strobes;
        int          exp_off;
        int          exp_str;
        bit          seen;
        logic [31:0] exp_rd;
        wait_target = waits;
        stuck       = stuck_en;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = a;
        cmd_writedata = d;
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_address   = 2'($urandom);
        cmd_writedata = $urandom;
        off = 1; strobes = 0; seen = 1'b0;
        chk("busy_ready", 32'(cmd_ready), 32'd0);
        while (off < 64 && !seen) begin
            if (avm_chipselect) begin
                strobes++;
                chk("avm_addr", 32'(avm_address), 32'(a));
                chk("avm_write_n", 32'(avm_write_n), wr ? 32'd0 : 32'd1);
                chk("avm_read", 32'(avm_read), wr ? 32'd0 : 32'd1);
                if (wr) chk("avm_wdata", avm_writedata, d);
            end else begin
                chk("strobe_idle_wn", 32'(avm_write_n), 32'd1);
            end
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                off++;
            end
        end
        exp_off = stuck_en ? TO + 1 : 2 + waits + (wr ? 0 : L);
        exp_str = stuck_en ? TO : 1 + waits;
        exp_rd  = (wr || stuck_en) ? 32'h0 : ref_mem[a];
        chk("rsp_seen", 32'(seen), 32'd1);
        chk("rsp_latency", 32'(off), 32'(exp_off));
        chk("strobe_cycles", 32'(strobes), 32'(exp_str));
        chk("rsp_readdata", rsp_readdata, exp_rd);
        chk("rsp_error", 32'(rsp_error), stuck_en ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("rsp_single", 32'(rsp_valid), 32'd0);
        if (wr && !stuck_en) ref_mem[a] = d;
        stuck = 1'b0;
        wait_target = 0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  b_addr [10];
        logic [31:0] b_data [10];
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = 2'd0; cmd_writedata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_readdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_cmd(1'b1, 2'd0, 32'h0000_00C8, 0, 1'b0);
        do_cmd(1'b0, 2'd0, 32'h0, 0, 1'b0);
        do_cmd(1'b1, 2'd1, 32'h1234_5678, 5, 1'b0);
        do_cmd(1'b0, 2'd1, 32'h0, 3, 1'b0);

`ifdef LOCKIN_AVMM_CMD_TIMEOUT_EN
        do_cmd(1'b1, 2'd2, 32'hDEAD_0001, 0, 1'b1);
        do_cmd(1'b0, 2'd2, 32'h0, 0, 1'b1);
        do_cmd(1'b0, 2'd2, 32'h0, 1, 1'b0);
`endif

        // reset mid-transfer: no response, nothing written
        wait_target   = 1000;
        cmd_valid     = 1'b1;
        cmd_write     = 1'b1;
        cmd_address   = 2'd3;
        cmd_writedata = 32'hCAFE_F00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_cs", 32'(avm_chipselect), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        chk("mid_rst_write_n", 32'(avm_write_n), 32'd1);
        chk("mid_rst_read", 32'(avm_read), 32'd0);
        chk("mid_rst_addr", 32'(avm_address), 32'd0);
        chk("mid_rst_wdata", avm_writedata, 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        wait_target = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        end
        do_cmd(1'b0, 2'd3, 32'h0, 0, 1'b0);
        do_cmd(1'b1, 2'd3, 32'h0BAD_CAFE, 1, 1'b0);
        do_cmd(1'b0, 2'd3, 32'h0, 0, 1'b0);

        // randomized traffic against the reference bank
        for (int k = 0; k < 24; k++) begin
            do_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                   int'($urandom_range(0, 3)), 1'b0);
        end

        // back-to-back writes with cmd_valid held high
        begin
            int acc = 0;
            int rsp = 0;
            int last = 0;
            int wrs = 0;
            bit fire;
            for (int i = 0; i < 10; i++) begin
                b_addr[i] = 2'(i);
                b_data[i] = $urandom;
            end
            cmd_write     = 1'b1;
            cmd_address   = b_addr[0];
            cmd_writedata = b_data[0];
            cmd_valid     = 1'b1;
            for (int c = 0; c < 80 && rsp < 10; c++) begin
                if (avm_chipselect && acc > 0) begin
                    wrs++;
                    chk("b2b_addr", 32'(avm_address), 32'(b_addr[acc-1]));
                    chk("b2b_wdata", avm_writedata, b_data[acc-1]);
                    chk("b2b_write_n", 32'(avm_write_n), 32'd0);
                end
                if (rsp_valid) rsp++;
                fire = cmd_ready && cmd_valid;
                if (fire) begin
                    if (acc > 0) chk("b2b_interval", 32'(c - last), 32'd3);
                    last = c;
                    acc++;
                end
                @(negedge clk);
                if (fire) begin
                    if (acc < 10) begin
                        cmd_address   = b_addr[acc];
                        cmd_writedata = b_data[acc];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
            end
            chk("b2b_accepts", 32'(acc), 32'd10);
            chk("b2b_rsp_count", 32'(rsp), 32'd10);
            chk("b2b_write_strobes", 32'(wrs), 32'd10);
            for (int i = 0; i < 10; i++) ref_mem[b_addr[i]] = b_data[i];
            repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 4; i++) do_cmd(1'b0, 2'(i), 32'h0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
